// File: rtl/j1_io_pkg.sv
// ============================================================================
// j1_io_pkg : register indices and bit positions for the J1 I/O timer/irq block
// Revision  : 1.0
// ============================================================================
`default_nettype none

package j1_io_pkg;

  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_RELOAD = 3'd1;
  localparam logic [2:0] REG_COUNT  = 3'd2;
  localparam logic [2:0] REG_STATUS = 3'd3;
  localparam logic [2:0] REG_FRAMES = 3'd4;

  localparam int CTRL_TEN  = 0;
  localparam int CTRL_AUTO = 1;
  localparam int CTRL_TIE  = 2;
  localparam int CTRL_VIE  = 3;

  localparam int STAT_TP = 0;
  localparam int STAT_VP = 1;

endpackage

`default_nettype wire

// File: rtl/j1_prescaled_down_counter.sv
// ============================================================================
// j1_prescaled_down_counter : prescaler plus 16-bit down counter with load,
//                             auto-reload and a one-cycle expire indication
// Revision                  : 1.0
// ============================================================================
`default_nettype none

module j1_prescaled_down_counter #(
  parameter int unsigned PRESC_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        auto_reload,
  input  logic [15:0] reload_val,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic [15:0] count,
  output logic        expire
);

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [15:0]        count_q, count_d;

  // expire is asserted for the edge on which COUNT steps 1 -> 0; a load masks it
  always_comb begin
    presc_d = presc_q;
    count_d = count_q;
    expire  = 1'b0;
    if (load) begin
      count_d = load_val;
      presc_d = '0;
    end else if (en && (count_q != 16'd0)) begin
      presc_d = presc_q + 1'b1;
      if (&presc_q) begin
        if (count_q == 16'd1) begin
          expire  = 1'b1;
          count_d = auto_reload ? reload_val : 16'd0;
        end else begin
          count_d = count_q - 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      count_q <= 16'd0;
    end else begin
      presc_q <= presc_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/j1_io_timer_irq.sv
// ============================================================================
// j1_io_timer_irq : J1 I/O bus responder with prescaled timer, vsync frame
//                   counter and level interrupt request
// Revision        : 1.0
// ============================================================================
`default_nettype none

module j1_io_timer_irq
  import j1_io_pkg::*;
#(
  parameter logic [15:0] BASE    = 16'hF000,
  parameter int unsigned PRESC_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        io_rd,
  input  logic        io_wr,
  input  logic [15:0] io_addr,
  input  logic [15:0] io_dout,
  output logic [15:0] io_din,
  input  logic        vsync,
  output logic        int_req
);

  logic        hit, wr_en;
  logic [2:0]  idx;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [15:0] reload_q, reload_d;
  logic        tp_q, tp_d, vp_q, vp_d;
  logic [15:0] frames_q, frames_d;
  logic        vsync_q;
  logic        int_req_q, int_req_d;
  logic        rise, expire, count_load, status_wr;
  logic [15:0] count;
  logic [15:0] rd_data;

  assign hit        = (io_addr[15:3] == BASE[15:3]);
  assign idx        = io_addr[2:0];
  assign wr_en      = io_wr & hit;
  assign count_load = wr_en && (idx == REG_COUNT);
  assign status_wr  = wr_en && (idx == REG_STATUS);
  assign rise       = vsync & ~vsync_q;

  j1_prescaled_down_counter #(
    .PRESC_W (PRESC_W)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .en          (ctrl_q[CTRL_TEN]),
    .auto_reload (ctrl_q[CTRL_AUTO]),
    .reload_val  (reload_q),
    .load        (count_load),
    .load_val    (io_dout),
    .count       (count),
    .expire      (expire)
  );

  // Hardware sets beat W1C clears; CPU writes beat hardware updates elsewhere
  always_comb begin
    ctrl_d = ctrl_q;
    if (expire && !ctrl_q[CTRL_AUTO]) ctrl_d[CTRL_TEN] = 1'b0;
    if (wr_en && (idx == REG_CTRL)) ctrl_d = io_dout[3:0];

    reload_d = (wr_en && (idx == REG_RELOAD)) ? io_dout : reload_q;

    tp_d = expire | (tp_q & ~(status_wr & io_dout[STAT_TP]));
    vp_d = rise   | (vp_q & ~(status_wr & io_dout[STAT_VP]));

    frames_d = frames_q;
    if (wr_en && (idx == REG_FRAMES)) frames_d = 16'd0;
    else if (rise)                    frames_d = frames_q + 16'd1;

    int_req_d = (tp_q & ctrl_q[CTRL_TIE]) | (vp_q & ctrl_q[CTRL_VIE]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q    <= 4'd0;
      reload_q  <= 16'hFFFF;
      tp_q      <= 1'b0;
      vp_q      <= 1'b0;
      frames_q  <= 16'd0;
      vsync_q   <= 1'b0;
      int_req_q <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      reload_q  <= reload_d;
      tp_q      <= tp_d;
      vp_q      <= vp_d;
      frames_q  <= frames_d;
      vsync_q   <= vsync;
      int_req_q <= int_req_d;
    end
  end

  always_comb begin
    rd_data = 16'h0000;
    case (idx)
      REG_CTRL:   rd_data = {12'h000, ctrl_q};
      REG_RELOAD: rd_data = reload_q;
      REG_COUNT:  rd_data = count;
      REG_STATUS: rd_data = {14'h0000, vp_q, tp_q};
      REG_FRAMES: rd_data = frames_q;
      default:    rd_data = 16'h0000;
    endcase
  end

  assign io_din  = (io_rd & hit) ? rd_data : 16'h0000;
  assign int_req = int_req_q;

endmodule

`default_nettype wire

// File: doc/j1_io_timer_irq.md
Name: j1_io_timer_irq

Overview:
- Device-side responder for the J1 CPU I/O bus. It decodes io_rd/io_wr cycles in a small register window and returns read data on io_din.
- Contains a programmable down-counting timer with prescaler, a vsync frame counter, and interrupt pending/enable logic. It drives the CPU's int_req input.
- Sits between the CPU I/O bus and the video timing block; it replaces the tied-off interrupt line.

Parameters:
- BASE, 16'hF000, base I/O address of the 8-word register window. Must be 8-aligned.
- PRESC_W, 4, prescaler width. The timer decrements once every 2**PRESC_W clocks.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- io_rd  in  1  CPU read strobe, single cycle
- io_wr  in  1  CPU write strobe, single cycle
- io_addr  in  16  CPU I/O address
- io_dout  in  16  CPU write data
- io_din  out  16  read data to CPU
- vsync  in  1  frame sync, synchronous to clk, active high, level
- int_req  out  1  interrupt request to CPU, level

Behaviour:
- Address decode: hit = (io_addr[15:3] == BASE[15:3]); reg index = io_addr[2:0]. Index 5..7 is reserved: reads return 0, writes are ignored.
- Register map:
  - 0 CTRL rw:
    - bit0 TEN, timer enable
    - bit1 AUTO, auto-reload
    - bit2 TIE, timer irq enable
    - bit3 VIE, vsync irq enable
    - other bits read 0
  - 1 RELOAD rw, 16 bit.
  - 2 COUNT: read gives the current count; write loads the count and clears the prescaler.
  - 3 STATUS:
    - bit0 TP, timer pending; bit1 VP, vsync pending.
    - Write-1-to-clear; writing 0 has no effect.
  - 4 FRAMES: read gives the 16-bit vsync rising-edge count; any write clears it to 0.
- Reads:
  - io_din is combinational: the selected register when io_rd & hit, else 16'h0000. Latency is 0 (same cycle).
  - Reads have no side effects.
- Writes: take effect at the rising edge on which io_wr & hit.
- Reset values:
  - CTRL = 0, RELOAD = 16'hFFFF, COUNT = 0, prescaler = 0, TP = VP = 0, FRAMES = 0, vsync_q = 0.
  - int_req = 0; io_din = 0.
- Timer:
  - While TEN = 1 and COUNT != 0, the prescaler increments every clock.
  - On prescaler wrap (all ones -> 0), COUNT decrements.
  - When COUNT steps 1 -> 0:
    - TP is set.
    - If AUTO = 1, COUNT is loaded with RELOAD on that same edge (no extra cycle at 0).
    - If AUTO = 0, COUNT stays 0 and TEN clears to 0.
  - TEN = 1 with COUNT = 0 leaves the timer idle and never sets TP.
  - TEN = 0 holds both COUNT and the prescaler.
- Vsync:
  - vsync_q registers vsync every clock; rise = vsync & ~vsync_q.
  - On rise: VP is set and FRAMES increments. FRAMES wraps FFFF -> 0000.
- int_req = registered value of (TP & TIE) | (VP & VIE). It asserts 1 cycle after the pending bit sets and holds until the bit is cleared or disabled.
- Simultaneous events:
  - COUNT write in the same cycle as a decrement or reload: the write wins and TP is not set that cycle.
  - Hardware set of TP/VP in the same cycle as a W1C of that bit: the set wins and the bit stays 1.
  - FRAMES write in the same cycle as rise: the write wins and FRAMES = 0.
  - CTRL write clearing TEN in the same cycle as expiry: TEN = 0, TP still set.
- io_rd and io_wr high together: the write is performed and io_din shows the pre-write value.
- rst asserted mid-count or with interrupts pending returns everything to reset values on the next edge.

Decomposition:
- Shared package j1_io_pkg holds:
  - register index constants REG_CTRL..REG_FRAMES
  - CTRL bit positions TEN/AUTO/TIE/VIE
  - STATUS bit positions TP/VP
- One natural sub-module, j1_prescaled_down_counter: prescaler plus 16-bit count with load, reload and expire pulse.
- Decode, registers and irq logic stay in the top.

Test Plan:
- Reset then read idx 0..7: CTRL = 0, RELOAD = FFFF, COUNT = 0, STATUS = 0, FRAMES = 0, idx 5..7 = 0, int_req = 0. Read at F008 (outside window) gives io_din = 0.
- One-shot, PRESC_W = 4:
  - Stimulus: write COUNT = 3, CTRL = 5 (TEN, TIE).
  - TP sets after exactly 48 clocks; int_req rises 1 cycle later.
  - CTRL reads 4 (TEN cleared) and COUNT = 0.
  - Write STATUS = 1: int_req drops the next cycle.
- Auto-reload:
  - Stimulus: RELOAD = 2, COUNT = 2, CTRL = 3.
  - TP sets every 32 clocks.
  - COUNT never reads 0 with AUTO = 1.
- Vsync:
  - Stimulus: CTRL = 8; 3 vsync pulses, each 4 cycles wide.
  - FRAMES = 3, VP = 1, int_req = 1 (one rise counted per pulse).
  - Write FRAMES = x: FRAMES reads 0.
  - Preload FRAMES to FFFF via 65535 pulses (or use a force in the bench); the next pulse gives 0000.
- Collisions:
  - W1C STATUS = 2 on the same edge as a vsync rise: VP stays 1.
  - COUNT write of 7 on the expiry edge: COUNT = 7, TP = 0.
- Reset mid-operation: assert rst while the timer is running and TP = VP = 1. On the next edge all registers are at reset values and int_req = 0.
